vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates VGA raster timing on the pixel clock.
- Its `display_area` output drives the 8-bit parallel-to-serial pixel shifter directly, so it is the shifter's immediate upstream stage.
- Also supplies raw pixel coordinates for the upstream glyph/byte fetch, and delays sync/blank outputs so they align with that fetch latency.
- The shifter restarts its bit counter whenever `display_area` is low. `display_area` must therefore rise exactly on pixel 0 of each visible line, already compensated for fetch latency.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- PIPE_DLY, 2, extra cycles applied to hsync/vsync/display_area/frame_start to match fetch latency (0..7)

Ports:
- vga_clk  in  1  pixel clock (25.175 MHz nominal)
- reset  in  1  asynchronous, active-low reset
- enable  in  1  counting enable; when low, counters and all outputs hold
- pixel_x  out  10  horizontal counter, undelayed (fetch address)
- pixel_y  out  10  vertical counter, undelayed
- hsync  out  1  horizontal sync, delayed by PIPE_DLY
- vsync  out  1  vertical sync, delayed by PIPE_DLY
- display_area  out  1  high during visible pixels, delayed by PIPE_DLY
- frame_start  out  1  one-cycle pulse at pixel (0,0), delayed by PIPE_DLY
- line_end  out  1  one-cycle pulse on the last pixel of every line (h = H_TOTAL-1), undelayed

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525. Counters are 10-bit unsigned. Elaboration fails if H_TOTAL > 1024, V_TOTAL > 1024, or PIPE_DLY > 7.
- Reset (reset == 0, asynchronous):
  - pixel_x = 0, pixel_y = 0
  - hsync = ~HS_POL, vsync = ~VS_POL (inactive levels)
  - display_area = 0, frame_start = 0, line_end = 0
  - all delay-line stages load these inactive values
- Counting (enable == 1):
  - h increments every cycle and wraps from H_TOTAL-1 to 0.
  - On that wrap, v increments and wraps from V_TOTAL-1 to 0.
  - h and v update in the same edge; there is no intermediate state.
- Stage-0 decode, registered, computed from the current counter values:
  - disp0 = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hs0 = HS_POL while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL
  - vs0 = VS_POL while V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL; vsync changes only together with an h wrap
  - fs0 = (h == 0 && v == 0)
- Output latency:
  - pixel_x/pixel_y are the counter registers themselves (latency 0).
  - Stage-0 signals are valid one cycle after the counters show the value.
  - hsync/vsync/display_area/frame_start pass through a further PIPE_DLY-stage shift register, giving total latency 1+PIPE_DLY relative to pixel_x/y.
  - With PIPE_DLY = 0 the outputs come straight from the stage-0 registers.
- display_area stays high for exactly H_ACTIVE consecutive cycles per visible line, with no glitch between lines. This count is a multiple of 8, so the shifter's 3-bit counter returns to 0 at each line end.
- enable low:
  - counters, decode registers and delay line all freeze (global clock-enable).
  - On re-enable, timing resumes at the exact frozen point.
- Reset mid-frame: all outputs go immediately to their inactive values. After release, the first visible pixel has pixel_x = 0, pixel_y = 0; display_area rises 1+PIPE_DLY cycles later, coincident with frame_start.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 constants (H_/V_ ACTIVE, FP, SYNC, BP, TOTAL)
  - counter width constant COORD_W = 10
  - polarity constants
- One sub-module, vga_pipe_delay:
  - parameterised width and depth shift register (4 bits wide here: hsync, vsync, display_area, frame_start)
  - per-bit reset values, async active-low reset, enable input
  - depth 0 = pass-through

Test Plan:
- Reset held low, then released at cycle 10 with defaults → outputs hold reset values while low; pixel_x = 0,1,2… after release; display_area first high 3 cycles after pixel_x = 0 and stays high 640 cycles; frame_start high for 1 cycle aligned with that rise.
- Line timing → display_area falls after 640 cycles. hsync goes low 16 cycles after display_area falls and stays low 96 cycles. Period is 800 cycles; line_end pulses when pixel_x = 799.
- Frame wrap over 525*800 = 420000 cycles → vsync low for exactly 1600 cycles, starting at line 490. pixel_y wraps 524 → 0 on the same edge that pixel_x wraps 799 → 0; frame_start pulses once per frame.
- PIPE_DLY = 0 and PIPE_DLY = 5 builds → display_area rise lags pixel_x = 0 by 1 and 6 cycles respectively. hsync and vsync offsets shift identically.
- enable low for 37 cycles mid-line (pixel_x = 300) → all outputs frozen during the gap. After re-enable, remaining visible run is 340 cycles; downstream shifter byte alignment is preserved (pixel count per line ≡ 0 mod 8).
- reset asserted at pixel (400, 200) → outputs inactive within the same cycle (asynchronous). After release, counting restarts from (0,0); no partial display_area pulse.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and types for the VGA timing generator.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic HS_POL = 1'b0;
  localparam logic VS_POL = 1'b0;

  localparam int PIPE_DLY_MAX = 7;
  localparam int SYNC_W       = 4;

  typedef struct packed {
    logic frame_start;
    logic display_area;
    logic vsync;
    logic hsync;
  } sync_bits_t;

  // Inactive level of every delayed timing bit for the given sync polarities.
  function automatic sync_bits_t idle_bits(input logic hs_pol, input logic vs_pol);
    sync_bits_t b;
    b.frame_start  = 1'b0;
    b.display_area = 1'b0;
    b.vsync        = ~vs_pol;
    b.hsync        = ~hs_pol;
    return b;
  endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// Clock-enabled shift register with per-bit reset values; DEPTH of 0 is a wire.
module vga_pipe_delay #(
  parameter int               WIDTH   = vga_timing_pkg::SYNC_W,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  import vga_timing_pkg::*;

  if (DEPTH < 0 || DEPTH > PIPE_DLY_MAX) begin : g_bad_depth
    $error("vga_pipe_delay: DEPTH out of range");
  end

  if (DEPTH == 0) begin : g_bypass
    logic unused_s;
    assign unused_s = ^{vga_clk, reset, enable};
    assign dout     = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_r [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
        // First stage captures the input word.
        always_ff @(posedge vga_clk or negedge reset) begin
          if (!reset) begin
            stage_r[k] <= RST_VAL;
          end else if (enable) begin
            stage_r[k] <= din;
          end
        end
      end else begin : g_tail
        // Later stages copy their predecessor.
        always_ff @(posedge vga_clk or negedge reset) begin
          if (!reset) begin
            stage_r[k] <= RST_VAL;
          end else if (enable) begin
            stage_r[k] <= stage_r[k-1];
          end
        end
      end
    end

    assign dout = stage_r[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: undelayed pixel coordinates for fetch, sync/blank delayed to
// line up with the fetch pipeline feeding the pixel shifter.
module vga_timing_gen #(
  parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_timing_pkg::H_FP,
  parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int   H_BP     = vga_timing_pkg::H_BP,
  parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_timing_pkg::V_FP,
  parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int   V_BP     = vga_timing_pkg::V_BP,
  parameter logic HS_POL   = vga_timing_pkg::HS_POL,
  parameter logic VS_POL   = vga_timing_pkg::VS_POL,
  parameter int   PIPE_DLY = 2
) (
  input  logic                               vga_clk,
  input  logic                               reset,
  input  logic                               enable,
  output logic [vga_timing_pkg::COORD_W-1:0] pixel_x,
  output logic [vga_timing_pkg::COORD_W-1:0] pixel_y,
  output logic                               hsync,
  output logic                               vsync,
  output logic                               display_area,
  output logic                               frame_start,
  output logic                               line_end
);
  import vga_timing_pkg::*;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [COORD_W-1:0] COORD_ZERO = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] COORD_ONE  = {{(COORD_W-1){1'b0}}, 1'b1};
  localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_PRELAST  = COORD_W'(H_TOTAL - 2);
  localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);

  localparam sync_bits_t IDLE_BITS = idle_bits(HS_POL, VS_POL);

  if (H_TOTAL > 1024 || H_TOTAL < 2) begin : g_bad_h
    $error("vga_timing_gen: H_TOTAL does not fit the 10-bit counter");
  end
  if (V_TOTAL > 1024 || V_TOTAL < 1) begin : g_bad_v
    $error("vga_timing_gen: V_TOTAL does not fit the 10-bit counter");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > PIPE_DLY_MAX) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY out of range");
  end

  logic [COORD_W-1:0] h_r;
  logic [COORD_W-1:0] v_r;
  logic               line_end_r;
  int                 h_int_s;
  int                 v_int_s;
  sync_bits_t         decode_s;
  sync_bits_t         stage0_r;
  sync_bits_t         delayed_s;

  // Raster counters; line_end is registered from the pre-last pixel so it lines up with h = H_TOTAL-1.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      h_r        <= COORD_ZERO;
      v_r        <= COORD_ZERO;
      line_end_r <= 1'b0;
    end else if (enable) begin
      if (h_r == H_LAST) begin
        h_r <= COORD_ZERO;
        v_r <= (v_r == V_LAST) ? COORD_ZERO : (v_r + COORD_ONE);
      end else begin
        h_r <= h_r + COORD_ONE;
      end
      line_end_r <= (h_r == H_PRELAST);
    end
  end

  assign h_int_s = {{(32-COORD_W){1'b0}}, h_r};
  assign v_int_s = {{(32-COORD_W){1'b0}}, v_r};

  // Stage-0 decode of the current counter position.
  always_comb begin
    decode_s              = IDLE_BITS;
    decode_s.display_area = (h_int_s < H_ACTIVE) && (v_int_s < V_ACTIVE);
    decode_s.hsync        = ((h_int_s >= HS_START) && (h_int_s < HS_END)) ? HS_POL : ~HS_POL;
    decode_s.vsync        = ((v_int_s >= VS_START) && (v_int_s < VS_END)) ? VS_POL : ~VS_POL;
    decode_s.frame_start  = (h_r == COORD_ZERO) && (v_r == COORD_ZERO);
  end

  // Stage-0 register: decode lags the counters by one cycle.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      stage0_r <= IDLE_BITS;
    end else if (enable) begin
      stage0_r <= decode_s;
    end
  end

  vga_pipe_delay #(
    .WIDTH   (SYNC_W),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (IDLE_BITS)
  ) u_pipe_delay (
    .vga_clk (vga_clk),
    .reset   (reset),
    .enable  (enable),
    .din     (stage0_r),
    .dout    (delayed_s)
  );

  assign pixel_x      = h_r;
  assign pixel_y      = v_r;
  assign line_end     = line_end_r;
  assign hsync        = delayed_s.hsync;
  assign vsync        = delayed_s.vsync;
  assign display_area = delayed_s.display_area;
  assign frame_start  = delayed_s.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 640x480 instance for line/enable timing, three reduced-raster
// instances (PIPE_DLY 0/2/5) for frame wrap, latency and mid-frame reset.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic       rst_a, en_a, rst_s, en_s;
  logic [9:0] px_a, py_a;
  logic       hs_a, vs_a, da_a, fs_a, le_a;
  logic [9:0] px_s [3];
  logic [9:0] py_s [3];
  logic       hs_s [3];
  logic       vs_s [3];
  logic       da_s [3];
  logic       fs_s [3];
  logic       le_s [3];

  int n_checks;
  int n_errors;

  vga_timing_gen u_dut_full (
    .vga_clk(vga_clk), .reset(rst_a), .enable(en_a),
    .pixel_x(px_a), .pixel_y(py_a), .hsync(hs_a), .vsync(vs_a),
    .display_area(da_a), .frame_start(fs_a), .line_end(le_a)
  );

  // Reduced raster: 16+2+4+2 = 24 pixels per line, 6+1+2+1 = 10 lines per frame.
  for (genvar g = 0; g < 3; g++) begin : g_small
    vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .PIPE_DLY((g == 0) ? 0 : ((g == 1) ? 2 : 5))
    ) u_dut_small (
      .vga_clk(vga_clk), .reset(rst_s), .enable(en_s),
      .pixel_x(px_s[g]), .pixel_y(py_s[g]), .hsync(hs_s[g]), .vsync(vs_s[g]),
      .display_area(da_s[g]), .frame_start(fs_s[g]), .line_end(le_s[g])
    );
  end

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rise1, rise2, fall1, hsf, hsr, le1, le1_px, le2, le_cnt, fs_cnt, fs_k;
    int run, vis, px_bad, py_800, vs_low, guard, frozen_bad, px_after;
    int rise_s [3];
    int hsf_s [3];
    int vsf_s [3];
    int vsl_s [3];
    int fsc_s [3];
    logic prev_da, prev_hs;
    logic prev_da_s [3];
    logic prev_hs_s [3];
    logic prev_vs_s [3];
    logic [25:0] snap;

    n_checks = 0;
    n_errors = 0;
    rst_a = 1'b0; en_a = 1'b1;
    rst_s = 1'b0; en_s = 1'b1;

    // ---------------- reset state, full raster ----------------
    repeat (5) tick();
    check_val("rst_pixel_x", int'(px_a), 0);
    check_val("rst_pixel_y", int'(py_a), 0);
    check_val("rst_hsync", int'(hs_a), 1);
    check_val("rst_vsync", int'(vs_a), 1);
    check_val("rst_display", int'(da_a), 0);
    check_val("rst_frame_start", int'(fs_a), 0);
    check_val("rst_line_end", int'(le_a), 0);
    repeat (5) tick();
    rst_a = 1'b1;

    // ---------------- first two lines after release ----------------
    rise1 = -1; rise2 = -1; fall1 = -1; hsf = -1; hsr = -1;
    le1 = -1; le1_px = -1; le2 = -1; le_cnt = 0; fs_cnt = 0; fs_k = -1;
    run = 0; px_bad = 0; py_800 = -1; vs_low = 0;
    prev_da = da_a; prev_hs = hs_a;
    for (int k = 0; k < 1700; k++) begin
      if (int'(px_a) != (k % 800)) px_bad++;
      if (k == 800) py_800 = int'(py_a);
      if (da_a && k < 800) run++;
      if (!vs_a) vs_low++;
      if (da_a && !prev_da) begin
        if (rise1 < 0) rise1 = k;
        else if (rise2 < 0) rise2 = k;
      end
      if (!da_a && prev_da && fall1 < 0) fall1 = k;
      if (!hs_a && prev_hs && hsf < 0) hsf = k;
      if (hs_a && !prev_hs && hsr < 0) hsr = k;
      if (le_a) begin
        le_cnt++;
        if (le1 < 0) begin
          le1 = k;
          le1_px = int'(px_a);
        end else if (le2 < 0) begin
          le2 = k;
        end
      end
      if (fs_a) begin
        fs_cnt++;
        fs_k = k;
      end
      prev_da = da_a;
      prev_hs = hs_a;
      tick();
    end
    check_val("pixel_x_sequence_errors", px_bad, 0);
    check_val("display_first_rise", rise1, 3);
    check_val("frame_start_cycle", fs_k, 3);
    check_val("frame_start_count", fs_cnt, 1);
    check_val("display_first_fall", fall1, 643);
    check_val("display_run_line0", run, 640);
    check_val("hsync_fall", hsf, 659);
    check_val("hsync_rise", hsr, 755);
    check_val("line_end_first", le1, 799);
    check_val("line_end_pixel_x", le1_px, 799);
    check_val("line_end_second", le2, 1599);
    check_val("line_end_count", le_cnt, 2);
    check_val("display_second_rise", rise2, 803);
    check_val("pixel_y_line1", py_800, 1);
    check_val("vsync_low_in_visible", vs_low, 0);

    // ---------------- enable gap at pixel_x = 300 ----------------
    guard = 0;
    while (px_a != 10'd0 && guard < 1000) begin
      tick();
      guard++;
    end
    check_val("seek_line_start_timeout", int'(guard >= 1000), 0);
    run = 0; guard = 0;
    while (px_a != 10'd300 && guard < 1000) begin
      if (da_a) run++;
      tick();
      guard++;
    end
    check_val("run_before_gap", run, 297);
    en_a = 1'b0;
    snap = {px_a, py_a, hs_a, vs_a, da_a, fs_a, le_a, 1'b0};
    frozen_bad = 0;
    for (int i = 0; i < 37; i++) begin
      tick();
      if ({px_a, py_a, hs_a, vs_a, da_a, fs_a, le_a, 1'b0} != snap) frozen_bad++;
    end
    check_val("frozen_changes", frozen_bad, 0);
    check_val("frozen_pixel_x", int'(px_a), 300);
    check_val("frozen_display", int'(da_a), 1);
    en_a = 1'b1;
    vis = 0; guard = 0; px_after = -1;
    while ((da_a || px_a <= 10'd640) && guard < 2000) begin
      if (guard == 1) px_after = int'(px_a);
      if (px_a < 10'd640) vis++;
      if (da_a) run++;
      tick();
      guard++;
    end
    check_val("resume_pixel_x", px_after, 301);
    check_val("remaining_visible_fetch", vis, 340);
    check_val("display_run_with_gap", run, 640);
    check_val("display_run_mod8", run % 8, 0);

    // ---------------- reduced raster: latency and frame wrap ----------------
    check_val("small_rst_display_d5", int'(da_s[2]), 0);
    check_val("small_rst_vsync_d0", int'(vs_s[0]), 1);
    rst_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rise_s[i] = -1; hsf_s[i] = -1; vsf_s[i] = -1; vsl_s[i] = 0; fsc_s[i] = 0;
      prev_da_s[i] = da_s[i]; prev_hs_s[i] = hs_s[i]; prev_vs_s[i] = vs_s[i];
    end
    for (int k = 0; k < 480; k++) begin
      if (k == 23) check_val("small_line_end_k23", int'(le_s[0]), 1);
      if (k == 239) begin
        check_val("small_wrap_pre_x", int'(px_s[0]), 23);
        check_val("small_wrap_pre_y", int'(py_s[0]), 9);
      end
      if (k == 240) begin
        check_val("small_wrap_post_x", int'(px_s[0]), 0);
        check_val("small_wrap_post_y", int'(py_s[0]), 0);
      end
      for (int i = 0; i < 3; i++) begin
        if (da_s[i] && !prev_da_s[i] && rise_s[i] < 0) rise_s[i] = k;
        if (!hs_s[i] && prev_hs_s[i] && hsf_s[i] < 0) hsf_s[i] = k;
        if (!vs_s[i] && prev_vs_s[i] && vsf_s[i] < 0) vsf_s[i] = k;
        if (!vs_s[i] && k < 400) vsl_s[i]++;
        if (fs_s[i]) fsc_s[i]++;
        prev_da_s[i] = da_s[i]; prev_hs_s[i] = hs_s[i]; prev_vs_s[i] = vs_s[i];
      end
      tick();
    end
    check_val("dly0_display_rise", rise_s[0], 1);
    check_val("dly2_display_rise", rise_s[1], 3);
    check_val("dly5_display_rise", rise_s[2], 6);
    check_val("dly0_hsync_fall", hsf_s[0], 19);
    check_val("dly2_hsync_fall", hsf_s[1], 21);
    check_val("dly5_hsync_fall", hsf_s[2], 24);
    check_val("dly0_vsync_fall", vsf_s[0], 169);
    check_val("dly2_vsync_fall", vsf_s[1], 171);
    check_val("dly5_vsync_fall", vsf_s[2], 174);
    check_val("dly0_vsync_low_len", vsl_s[0], 48);
    check_val("dly5_vsync_low_len", vsl_s[2], 48);
    check_val("dly0_frame_starts", fsc_s[0], 2);
    check_val("dly5_frame_starts", fsc_s[2], 2);

    // ---------------- asynchronous reset mid-frame ----------------
    guard = 0;
    while (!(px_s[1] == 10'd10 && py_s[1] == 10'd5) && guard < 500) begin
      tick();
      guard++;
    end
    check_val("seek_mid_frame_timeout", int'(guard >= 500), 0);
    check_val("mid_frame_display_pre", int'(da_s[1]), 1);
    #2;
    rst_s = 1'b0;
    #1;
    check_val("async_rst_pixel_x", int'(px_s[1]), 0);
    check_val("async_rst_pixel_y", int'(py_s[1]), 0);
    check_val("async_rst_display", int'(da_s[1]), 0);
    check_val("async_rst_hsync", int'(hs_s[1]), 1);
    check_val("async_rst_display_d5", int'(da_s[2]), 0);
    repeat (3) tick();
    rst_s = 1'b1;
    run = 0; rise1 = -1; fs_k = -1; vis = 0;
    prev_da = da_s[1];
    for (int k = 0; k < 40; k++) begin
      if (k < 3 && da_s[1]) vis++;
      if (da_s[1] && !prev_da && rise1 < 0) rise1 = k;
      if (fs_s[1] && fs_k < 0) fs_k = k;
      if (da_s[1] && k < 24) run++;
      prev_da = da_s[1];
      tick();
    end
    check_val("post_rst_early_display", vis, 0);
    check_val("post_rst_display_rise", rise1, 3);
    check_val("post_rst_frame_start", fs_k, 3);
    check_val("post_rst_display_run", run, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
